cassette_status: RTL and testbench



---
 rtl/cassette_pkg.sv | 14 +
 rtl/cassette_level_meter.sv | 70 +++++++
 rtl/cassette_status.sv | 135 +++++++++++++
 tb/tb_cassette_status.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cassette_pkg.sv
// Shared types and widths for the cassette status tracker and its overlay.
package cassette_pkg;

    localparam int unsigned TAPE_AW = 25;
    localparam int unsigned LEVEL_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2,
        ST_PLAYING = 2'd3
    } state_e;

endpackage

// File: rtl/cassette_level_meter.sv
// Per-frame activity level from cassette bit edges, with peak-hold and linear decay.
module cassette_level_meter
    import cassette_pkg::*;
#(
    parameter int unsigned DECAY = 4,
    parameter int unsigned SHIFT = 2
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               en,
    input  logic               audio_in,
    input  logic               frame_tick,
    output logic [LEVEL_W-1:0] tape_data
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned LVL_RAW_W = 10;

    logic                 audio_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [LEVEL_W-1:0]   tape_q;
    logic [LEVEL_W-1:0]   tape_d;
    logic                 toggle_c;
    logic [LVL_RAW_W-1:0] level_raw_c;
    logic [LEVEL_W-1:0]   level_c;
    logic [LEVEL_W-1:0]   decayed_c;

    always_comb begin
        toggle_c    = audio_in ^ audio_q;
        level_raw_c = LVL_RAW_W'(count_q) << SHIFT;
        level_c     = (level_raw_c > LVL_RAW_W'(255)) ? '1 : level_raw_c[LEVEL_W-1:0];
        decayed_c   = (tape_q > LEVEL_W'(DECAY)) ? tape_q - LEVEL_W'(DECAY) : '0;

        count_d = count_q;
        tape_d  = tape_q;

        // An edge landing on the tick cycle belongs to the next frame.
        if (!en) begin
            count_d = '0;
        end else if (frame_tick) begin
            count_d = CNT_W'(toggle_c);
        end else if (toggle_c && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        if (frame_tick) begin
            if (en && (level_c >= tape_q)) begin
                tape_d = level_c;
            end else begin
                tape_d = decayed_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            audio_q <= 1'b0;
            count_q <= '0;
            tape_q  <= '0;
        end else begin
            audio_q <= audio_in;
            count_q <= count_d;
            tape_q  <= tape_d;
        end
    end

    assign tape_data = tape_q;

endmodule

// File: rtl/cassette_status.sv
// Tape image size, playback position, player state and activity meter for the cassette overlay.
module cassette_status
    import cassette_pkg::*;
#(
    parameter int unsigned DECAY       = 4,
    parameter int unsigned SHIFT       = 2,
    parameter int unsigned IDLE_FRAMES = 50
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               loading,
    input  logic               load_wr,
    input  logic [TAPE_AW-1:0] load_addr,
    input  logic               rd_strobe,
    input  logic [TAPE_AW-1:0] rd_addr,
    input  logic               rewind,
    input  logic               audio_in,
    input  logic               frame_tick,
    output logic [TAPE_AW-1:0] max,
    output logic [TAPE_AW-1:0] pos,
    output logic [LEVEL_W-1:0] tape_data,
    output logic               active,
    output logic [1:0]         state
);

    localparam int unsigned IDLE_W = $clog2(IDLE_FRAMES + 1);

    state_e             state_q;
    state_e             state_d;
    logic [TAPE_AW-1:0] max_q;
    logic [TAPE_AW-1:0] max_d;
    logic [TAPE_AW-1:0] pos_q;
    logic [TAPE_AW-1:0] pos_d;
    logic [IDLE_W-1:0]  idle_q;
    logic [IDLE_W-1:0]  idle_d;
    logic               loading_q;
    logic               active_q;
    logic               active_d;
    logic               load_rise_c;
    logic [TAPE_AW:0]   wr_end_c;
    logic [TAPE_AW-1:0] wr_size_c;

    always_comb begin
        load_rise_c = loading & ~loading_q;
        wr_end_c    = {1'b0, load_addr} + (TAPE_AW + 1)'(1);
        wr_size_c   = wr_end_c[TAPE_AW] ? '1 : wr_end_c[TAPE_AW-1:0];

        state_d = state_q;
        max_d   = max_q;
        pos_d   = pos_q;
        idle_d  = '0;

        unique case (state_q)
            ST_LOADING: begin
                if (load_wr && (wr_size_c > max_q)) begin
                    max_d = wr_size_c;
                end
                if (!loading) begin
                    state_d = (max_d != '0) ? ST_READY : ST_EMPTY;
                end
            end
            ST_READY: begin
                if (rd_strobe) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                // A read in the same cycle as a tick keeps the player alive.
                if (rd_strobe) begin
                    idle_d = '0;
                end else if (frame_tick) begin
                    idle_d = idle_q + IDLE_W'(1);
                end else begin
                    idle_d = idle_q;
                end
                if (idle_d == IDLE_W'(IDLE_FRAMES)) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase

        if (rd_strobe && ((state_q == ST_READY) || (state_q == ST_PLAYING))) begin
            pos_d = (rd_addr < max_q) ? rd_addr : max_q;
        end
        if (rewind) begin
            pos_d = '0;
        end

        // A fresh download discards the old image from any state.
        if (load_rise_c) begin
            state_d = ST_LOADING;
            max_d   = '0;
            pos_d   = '0;
        end

        active_d = (state_d == ST_PLAYING);
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            max_q     <= '0;
            pos_q     <= '0;
            idle_q    <= '0;
            loading_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            pos_q     <= pos_d;
            idle_q    <= idle_d;
            loading_q <= loading;
            active_q  <= active_d;
        end
    end

    cassette_level_meter #(
        .DECAY (DECAY),
        .SHIFT (SHIFT)
    ) u_meter (
        .i_clk      (i_clk),
        .reset      (reset),
        .en         (state_q == ST_PLAYING),
        .audio_in   (audio_in),
        .frame_tick (frame_tick),
        .tape_data  (tape_data)
    );

    assign max    = max_q;
    assign pos    = pos_q;
    assign active = active_q;
    assign state  = state_q;

endmodule

// File: tb/tb_cassette_status.sv
// Directed and randomized bench for cassette_status against a behavioural model.
module tb_cassette_status;
    import cassette_pkg::*;

    localparam int DECAY       = 4;
    localparam int SHIFT       = 2;
    localparam int IDLE_FRAMES = 50;
    localparam int MAX_SIZE    = (1 << 25) - 1;

    logic               i_clk = 1'b0;
    logic               reset;
    logic               loading;
    logic               load_wr;
    logic [TAPE_AW-1:0] load_addr;
    logic               rd_strobe;
    logic [TAPE_AW-1:0] rd_addr;
    logic               rewind;
    logic               audio_in;
    logic               frame_tick;
    logic [TAPE_AW-1:0] max;
    logic [TAPE_AW-1:0] pos;
    logic [LEVEL_W-1:0] tape_data;
    logic               active;
    logic [1:0]         state;

    int n_vec = 0;
    int n_err = 0;

    // Model: state 0=EMPTY 1=LOADING 2=READY 3=PLAYING
    int m_state, m_max, m_pos, m_tape, m_edges, m_idle;
    bit m_prev_audio, m_prev_load;

    always #5 i_clk = ~i_clk;

    cassette_status #(
        .DECAY       (DECAY),
        .SHIFT       (SHIFT),
        .IDLE_FRAMES (IDLE_FRAMES)
    ) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .loading    (loading),
        .load_wr    (load_wr),
        .load_addr  (load_addr),
        .rd_strobe  (rd_strobe),
        .rd_addr    (rd_addr),
        .rewind     (rewind),
        .audio_in   (audio_in),
        .frame_tick (frame_tick),
        .max        (max),
        .pos        (pos),
        .tape_data  (tape_data),
        .active     (active),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Applies one clock of the current inputs to the reference model.
    task automatic model_step();
        int ns, nmax, npos, lvl, sz;
        bit toggle;
        if (reset) begin
            m_state = 0; m_max = 0; m_pos = 0; m_tape = 0;
            m_edges = 0; m_idle = 0; m_prev_audio = 0; m_prev_load = 0;
            return;
        end
        toggle = (audio_in != m_prev_audio);
        if (frame_tick) begin
            lvl = (m_state == 3) ? m_edges * (1 << SHIFT) : 0;
            if (lvl > 255) lvl = 255;
            if (lvl >= m_tape) m_tape = lvl;
            else m_tape = (m_tape > DECAY) ? m_tape - DECAY : 0;
        end
        if (m_state != 3)       m_edges = 0;
        else if (frame_tick)    m_edges = toggle ? 1 : 0;
        else if (toggle && m_edges < 255) m_edges++;
        m_prev_audio = audio_in;

        ns = m_state; nmax = m_max; npos = m_pos;
        case (m_state)
            1: begin
                if (load_wr) begin
                    sz = int'(load_addr) + 1;
                    if (sz > MAX_SIZE) sz = MAX_SIZE;
                    if (sz > nmax) nmax = sz;
                end
                if (!loading) ns = (nmax != 0) ? 2 : 0;
            end
            2: if (rd_strobe) begin ns = 3; m_idle = 0; end
            3: begin
                if (rd_strobe) m_idle = 0;
                else if (frame_tick) m_idle++;
                if (m_idle == IDLE_FRAMES) ns = 2;
            end
            default: ;
        endcase
        if (rd_strobe && (m_state == 2 || m_state == 3))
            npos = (int'(rd_addr) < m_max) ? int'(rd_addr) : m_max;
        if (rewind) npos = 0;
        if (loading && !m_prev_load) begin ns = 1; nmax = 0; npos = 0; end
        if (ns != 3) m_idle = 0;
        m_prev_load = loading;
        m_state = ns; m_max = nmax; m_pos = npos;
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_step();
        #1;
        check("state",     32'(state),     32'(m_state));
        check("max",       32'(max),       32'(m_max));
        check("pos",       32'(pos),       32'(m_pos));
        check("tape_data", 32'(tape_data), 32'(m_tape));
        check("active",    32'(active),    (m_state == 3) ? 32'd1 : 32'd0);
        load_wr = 1'b0; rd_strobe = 1'b0; rewind = 1'b0; frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; loading = 1'b0; load_wr = 1'b0; load_addr = '0;
        rd_strobe = 1'b0; rd_addr = '0; rewind = 1'b0; audio_in = 1'b0; frame_tick = 1'b0;
        m_state = 0; m_max = 0; m_pos = 0; m_tape = 0; m_edges = 0; m_idle = 0;
        m_prev_audio = 0; m_prev_load = 0;
        #2;
        cycle(); cycle();
        check("rst_state", 32'(state), 32'd0);
        check("rst_max",   32'(max),   32'd0);
        check("rst_tape",  32'(tape_data), 32'd0);
        reset = 1'b0;
        cycle();

        // Download 1000 bytes, with address 500 arriving last.
        loading = 1'b1; cycle();
        check("enter_loading", 32'(state), 32'd1);
        for (int a = 0; a < 1000; a++) begin
            if (a != 500) begin load_wr = 1'b1; load_addr = 25'(a); cycle(); end
        end
        load_wr = 1'b1; load_addr = 25'd500; cycle();
        check("max_after_load", 32'(max), 32'd1000);
        loading = 1'b0; cycle();
        check("ready_state", 32'(state), 32'd2);
        check("ready_max",   32'(max),   32'd1000);
        check("ready_pos",   32'(pos),   32'd0);

        rd_strobe = 1'b1; rd_addr = 25'd10; cycle();
        check("play_state",  32'(state),  32'd3);
        check("play_active", 32'(active), 32'd1);
        check("play_pos",    32'(pos),    32'd10);
        rd_strobe = 1'b1; rd_addr = 25'd5000; cycle();
        check("pos_clamp", 32'(pos), 32'd1000);

        // Level meter: peak, decay, saturation.
        repeat (20) begin audio_in = ~audio_in; cycle(); end
        frame_tick = 1'b1; cycle();
        check("level_80", 32'(tape_data), 32'd80);
        frame_tick = 1'b1; cycle();
        check("decay_76", 32'(tape_data), 32'd76);
        frame_tick = 1'b1; cycle();
        check("decay_72", 32'(tape_data), 32'd72);
        repeat (70) begin audio_in = ~audio_in; cycle(); end
        frame_tick = 1'b1; cycle();
        check("level_sat", 32'(tape_data), 32'd255);

        // Idle timeout, then the read-beats-tick case.
        rd_strobe = 1'b1; rd_addr = 25'd20; cycle();
        repeat (IDLE_FRAMES - 1) begin frame_tick = 1'b1; cycle(); cycle(); end
        check("idle_49", 32'(state), 32'd3);
        frame_tick = 1'b1; cycle();
        check("idle_50_state",  32'(state),  32'd2);
        check("idle_50_active", 32'(active), 32'd0);
        rd_strobe = 1'b1; rd_addr = 25'd25; cycle();
        repeat (IDLE_FRAMES - 1) begin frame_tick = 1'b1; cycle(); cycle(); end
        frame_tick = 1'b1; rd_strobe = 1'b1; rd_addr = 25'd30; cycle();
        check("tick_rd_same", 32'(state), 32'd3);

        rewind = 1'b1; rd_strobe = 1'b1; rd_addr = 25'd300; cycle();
        check("rewind_prio", 32'(pos), 32'd0);
        rd_strobe = 1'b1; rd_addr = 25'd400; cycle();
        loading = 1'b1; cycle();
        check("reload_state", 32'(state), 32'd1);
        check("reload_max",   32'(max),   32'd0);
        check("reload_pos",   32'(pos),   32'd0);

        load_wr = 1'b1; load_addr = 25'd99; cycle();
        loading = 1'b0; cycle();
        rd_strobe = 1'b1; rd_addr = 25'd50; cycle();
        repeat (30) begin audio_in = ~audio_in; cycle(); end
        frame_tick = 1'b1; cycle();
        check("level_120", 32'(tape_data), 32'd120);
        reset = 1'b1; cycle();
        check("midrst_state",  32'(state),     32'd0);
        check("midrst_tape",   32'(tape_data), 32'd0);
        check("midrst_pos",    32'(pos),       32'd0);
        check("midrst_active", 32'(active),    32'd0);
        reset = 1'b0;
        rd_strobe = 1'b1; rd_addr = 25'd77; cycle();
        check("empty_rd_pos", 32'(pos), 32'd0);

        // Randomized traffic: busy first half, sparse reads later so idle timeouts occur.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, (i < 2000) ? 63 : 599) == 0) loading = ~loading;
            load_wr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 31) == 0)
                load_addr = 25'h1FFFFFF - 25'($urandom_range(0, 1));
            else
                load_addr = 25'($urandom_range(0, 2047));
            rd_strobe  = ($urandom_range(0, (i < 2000) ? 3 : 150) == 0);
            rd_addr    = 25'($urandom_range(0, 3000));
            rewind     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2) == 0) audio_in = ~audio_in;
            frame_tick = ($urandom_range(0, (i < 2000) ? 9 : 2) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
